// File: rtl/spike_pkg.sv
// spike_pkg: shared types and default constants for the spike-detector
// frontend (FIR -> NEO emphasis -> adaptive-threshold detection).
//   sample_t    - signed 12-bit filtered sample, shared with the FIR
//   energy_t    - unsigned 24-bit NEO energy / threshold value
//   det_state_t - detection FSM states
//   sat24       - clamp a 32-bit unsigned value into 24 bits
package spike_pkg;

  typedef logic signed [11:0] sample_t;
  typedef logic [23:0]        energy_t;

  typedef enum logic [1:0] {
    WARMUP,
    ARMED,
    SPIKE,
    REFRACT
  } det_state_t;

  localparam int         DEF_SHIFT       = 6;
  localparam logic [7:0] DEF_K_Q3        = 8'd40;
  localparam energy_t    DEF_THR_MIN     = 24'd64;
  localparam int         DEF_WARM_LEN    = 256;
  localparam int         DEF_REFRACT_LEN = 32;

  // Anything with bits above 23 set is clamped to the largest energy value.
  function automatic energy_t sat24(input logic [31:0] v);
    return (v[31:24] != 8'd0) ? 24'hFFFFFF : v[23:0];
  endfunction

endpackage

// File: rtl/neo_core.sv
// neo_core: three-sample delay line plus registered Nonlinear Energy
// Operator psi = x1*x1 - x0*x2, with negative results clipped to zero.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset, clears delay line and psi
//   i_sample - signed filtered sample, a new one every cycle
//   o_psi    - clipped NEO value centred on the sample held in x1
module neo_core
  import spike_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t i_sample,
  output energy_t o_psi
);

  sample_t r_x0, r_x1, r_x2;
  energy_t r_psi;

  logic signed [23:0] w_x0e, w_x1e, w_x2e;
  logic signed [23:0] w_sq, w_cross;
  logic [24:0]        w_d;

  // Sign-extend to product width so the 24-bit products are exact
  // (12x12 signed products always fit in 24 signed bits).
  assign w_x0e   = {{12{r_x0[11]}}, r_x0};
  assign w_x1e   = {{12{r_x1[11]}}, r_x1};
  assign w_x2e   = {{12{r_x2[11]}}, r_x2};
  assign w_sq    = w_x1e * w_x1e;
  assign w_cross = w_x0e * w_x2e;
  assign w_d     = {w_sq[23], w_sq} - {w_cross[23], w_cross};

  // Delay line and clipped energy register; bit 24 of d is its sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0  <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_psi <= '0;
    end else begin
      r_x0  <= i_sample;
      r_x1  <= r_x0;
      r_x2  <= r_x1;
      r_psi <= w_d[24] ? 24'd0 : w_d[23:0];
    end
  end

  assign o_psi = r_psi;

endmodule

// File: rtl/neo_spike_detect.sv
// neo_spike_detect: NEO emphasis plus adaptive-threshold spike detection.
// The threshold is K_Q3/8 times an exponential mean of psi (window about
// 2^SHIFT samples), floored at THR_MIN. After reset the detector warms up
// for WARM_LEN cycles, then each detection produces a one-cycle spike pulse
// followed by REFRACT_LEN cycles of hold-off.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset, clears all state
//   p         - signed filtered sample from the FIR, one per cycle
//   psi       - registered clipped NEO value
//   thr       - registered current threshold
//   spike     - one-cycle detection pulse
//   armed     - high only while detection is armed
//   spike_cnt - saturating count of spike pulses
module neo_spike_detect
  import spike_pkg::*;
#(
  parameter int         SHIFT       = DEF_SHIFT,
  parameter logic [7:0] K_Q3        = DEF_K_Q3,
  parameter energy_t    THR_MIN     = DEF_THR_MIN,
  parameter int         WARM_LEN    = DEF_WARM_LEN,
  parameter int         REFRACT_LEN = DEF_REFRACT_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] p,
  output logic [23:0] psi,
  output logic [23:0] thr,
  output logic        spike,
  output logic        armed,
  output logic [15:0] spike_cnt
);

  localparam int          ACC_W     = 24 + SHIFT;
  localparam logic [15:0] WARM_LAST = 16'(WARM_LEN - 1);
  localparam logic [15:0] REF_LAST  = 16'(REFRACT_LEN - 1);

  energy_t          w_psi;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  energy_t          w_mean;
  logic [31:0]      w_prod;
  energy_t          w_scaled;
  energy_t          w_thr_next;
  logic             w_freeze;
  energy_t          r_thr;

  det_state_t  r_state;
  logic [15:0] r_warm_cnt;
  logic [15:0] r_ref_cnt;
  logic        r_spike;
  logic        r_armed;
  logic [15:0] r_spike_cnt;

  neo_core u_neo_core (
    .clk      (clk),
    .rst      (rst),
    .i_sample (sample_t'(p)),
    .o_psi    (w_psi)
  );

  // The spike itself must not inflate the threshold that follows it, so
  // the mean is frozen while the detector is pulsing or holding off.
  assign w_freeze   = (r_state == SPIKE) || (r_state == REFRACT);
  assign w_acc_next = r_acc - (r_acc >> SHIFT) + ACC_W'(w_psi);
  assign w_mean     = r_acc[ACC_W-1:SHIFT];

  // Q5.3 multiply: product of mean and K, then drop the 3 fraction bits.
  assign w_prod     = {8'd0, w_mean} * {24'd0, K_Q3};
  assign w_scaled   = sat24(w_prod >> 3);
  assign w_thr_next = (w_scaled < THR_MIN) ? THR_MIN : w_scaled;

  // Mean accumulator and threshold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_thr <= THR_MIN;
    end else begin
      if (!w_freeze) begin
        r_acc <= w_acc_next;
      end
      r_thr <= w_thr_next;
    end
  end

  // Detection FSM with registered spike/armed/count outputs. The
  // comparison uses the registered psi and thr of the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WARMUP;
      r_warm_cnt  <= '0;
      r_ref_cnt   <= '0;
      r_spike     <= 1'b0;
      r_armed     <= 1'b0;
      r_spike_cnt <= '0;
    end else begin
      r_spike <= 1'b0;
      case (r_state)
        WARMUP: begin
          if (r_warm_cnt == WARM_LAST) begin
            r_state <= ARMED;
            r_armed <= 1'b1;
          end else begin
            r_warm_cnt <= r_warm_cnt + 16'd1;
          end
        end
        ARMED: begin
          if (w_psi > r_thr) begin
            r_state <= SPIKE;
            r_spike <= 1'b1;
            r_armed <= 1'b0;
          end
        end
        SPIKE: begin
          if (r_spike_cnt != 16'hFFFF) begin
            r_spike_cnt <= r_spike_cnt + 16'd1;
          end
          r_ref_cnt <= '0;
          r_state   <= REFRACT;
        end
        REFRACT: begin
          if (r_ref_cnt == REF_LAST) begin
            r_state <= ARMED;
            r_armed <= 1'b1;
          end else begin
            r_ref_cnt <= r_ref_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= WARMUP;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign psi       = w_psi;
  assign thr       = r_thr;
  assign spike     = r_spike;
  assign armed     = r_armed;
  assign spike_cnt = r_spike_cnt;

endmodule

// File: doc/neo_spike_detect.md
Name: neo_spike_detect

Overview:
- Emphasis and detection stage directly downstream of the 8-tap low-pass FIR in the spike-detector frontend.
- Consumes one filtered 12-bit signed sample per clock.
- Computes the Nonlinear Energy Operator psi[n] = x[n]^2 - x[n+1]*x[n-1] and tracks an adaptive threshold, a scaled exponential mean of psi.
- Emits a one-cycle spike pulse followed by a refractory hold-off; also keeps a saturating event count.

Parameters:
- SHIFT, 6: mean window exponent; the mean averages about 2^SHIFT samples.
- K_Q3, 8'd40: threshold multiplier, unsigned Q5.3 (40 = 5.0).
- THR_MIN, 24'd64: threshold floor.
- WARM_LEN, 256: cycles after reset before detection is armed (must be ≥ 4).
- REFRACT_LEN, 32: refractory cycles after each spike (must be ≥ 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- p  in  12  signed filtered sample (FIR output), new value every cycle
- psi  out  24  unsigned clipped NEO value (registered)
- thr  out  24  unsigned current threshold (registered)
- spike  out  1  one-cycle detection pulse
- armed  out  1  high in ARMED state only
- spike_cnt  out  16  saturating count of spike pulses

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst and applies to all state. It takes effect mid-operation too: everything clears and the FSM returns to WARMUP.
- Reset values: psi=0, thr=THR_MIN, spike=0, armed=0, spike_cnt=0, delay line x0..x2=0, accumulator=0, FSM=WARMUP, counters=0.
- Delay line, every cycle: x0<=p, x1<=x0, x2<=x1.
- NEO datapath:
  - d = x1*x1 - x0*x2, 25-bit signed. Products are 24-bit signed and cannot overflow.
  - psi <= (d<0) ? 0 : d[23:0]. The maximum 2^23 fits in 24 unsigned bits.
- Timing: with sample s_n on p in cycle n, the psi centred on s_n is visible in cycle n+3. A resulting spike is visible in cycle n+4.
- Mean accumulator:
  - Width 24+SHIFT, unsigned.
  - Update acc <= acc - (acc>>SHIFT) + psi every cycle, except when the FSM is in SPIKE or REFRACT (frozen).
  - mean = acc>>SHIFT.
- Threshold register, every cycle: thr <= max(THR_MIN, sat24((mean*K_Q3)>>3)). The product is 32 bits; saturate to 24'hFFFFFF.
- FSM:
  - WARMUP: warm_cnt increments each cycle. At warm_cnt==WARM_LEN-1 go to ARMED. No spikes; psi exceedances are ignored.
  - ARMED: armed=1. If psi > thr (strict), go to SPIKE. spike is registered with this transition, so it is high for exactly the cycle spent in SPIKE.
  - SPIKE: single cycle. spike=1; spike_cnt increments unless it is 16'hFFFF. Next state REFRACT with ref_cnt=0.
  - REFRACT: ref_cnt increments. At ref_cnt==REFRACT_LEN-1 go to ARMED. Exceedances are ignored.
- Comparison uses the registered psi and thr of the same cycle.
- psi==thr does not trigger.
- spike_cnt holds at 16'hFFFF and never wraps.

Decomposition:
- Package spike_pkg holds:
  - typedef sample_t (logic signed [11:0]), shared with fir;
  - typedef energy_t (logic [23:0]);
  - FSM enum det_state_t {WARMUP, ARMED, SPIKE, REFRACT};
  - default parameter constants.
- One sub-module, neo_core: the delay line plus registered clipped psi, 1-cycle register latency.
- The FSM, mean and threshold logic stay in the top.

Test Plan:
- Constant p=100 for 1000 cycles:
  - psi stays 0 and thr stays 64.
  - spike never asserts; spike_cnt=0.
  - armed rises at cycle WARM_LEN after reset release.
- After armed, p=0 except p=200 in cycle n:
  - psi=40000 in cycle n+3 and 0 in neighbouring cycles.
  - spike=1 only in cycle n+4; spike_cnt=1.
  - armed low for cycles n+4..n+36 and high again at n+37.
- Same 200 impulse injected in cycle 50 after reset (WARMUP): spike never asserts; spike_cnt=0.
- Two 200 impulses after armed, 10 cycles apart: exactly one spike. Same pair 40 cycles apart: two spikes, at n+4 and n+44; spike_cnt=2.
- Sequence 100,0,100 centred on 0: d=-10000, so psi=0 and no spike.
- Assert rst for 1 cycle during REFRACT:
  - next cycle spike=0, spike_cnt=0, armed=0, psi=0, thr=64;
  - armed returns after WARM_LEN cycles.
